camera_capture_param: RTL and testbench

- Parametrised successor to the current two-byte camera read front end.
- Deserialises an 8-bit DVP-style camera bus (vsync/href/data) into pixels of BYTES_PER_PIXEL bytes.
- Tags every pixel with decimated x/y coordinates and supports integer power-of-two decimation.
- Provides line/frame strobes, a frame counter and sticky error flags; feeds the HSV threshold path and the frame buffer writer.

---
 rtl/camera_capture_param.sv | 134 +++++++++++++
 tb/tb_camera_capture_param.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_capture_param.sv
// Parametrised DVP camera front end: deserialises vsync/href/data into
// BYTES_PER_PIXEL-byte pixels, tags each kept pixel with decimated x/y,
// and reports line/frame strobes, a frame counter and sticky error flags.
module camera_capture_param #(
    parameter int BYTES_PER_PIXEL = 2,
    parameter int H_MAX           = 640,
    parameter int V_MAX           = 480,
    parameter int DEC_LOG2        = 0,
    parameter int FRAME_CNT_W     = 8
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         vsync_in,
    input  logic                         href_in,
    input  logic [7:0]                   p_data_in,
    output logic [8*BYTES_PER_PIXEL-1:0] pixel_data_out,
    output logic [$clog2(H_MAX)-1:0]     hcount_out,
    output logic [$clog2(V_MAX)-1:0]     vcount_out,
    output logic                         pixel_valid_out,
    output logic                         line_done_out,
    output logic                         frame_done_out,
    output logic [FRAME_CNT_W-1:0]       frame_count_out,
    output logic                         overflow_err_out,
    output logic                         align_err_out
);

    localparam int HW = $clog2(H_MAX);
    localparam int VW = $clog2(V_MAX);
    localparam int PW = 8 * BYTES_PER_PIXEL;

    // Source coordinates carry one extra bit so they can sit at H_MAX/V_MAX.
    localparam logic [HW:0] X_LIMIT    = (HW+1)'(H_MAX);
    localparam logic [VW:0] Y_LIMIT    = (VW+1)'(V_MAX);
    localparam logic [HW:0] X_MASK     = (HW+1)'((1 << DEC_LOG2) - 1);
    localparam logic [VW:0] Y_MASK     = (VW+1)'((1 << DEC_LOG2) - 1);
    localparam logic [1:0]  LAST_PHASE = 2'(BYTES_PER_PIXEL - 1);

    typedef enum logic [1:0] {
        SYNC,
        WAIT_START,
        CAPTURE
    } state_t;

    state_t         state;
    logic [HW:0]    src_x;
    logic [VW:0]    src_y;
    logic [1:0]     phase;
    logic           href_d;
    logic [PW-1:0]  byte_buf;
    logic [PW-1:0]  assembled;
    logic           byte_en;
    logic           in_range;
    logic           keep;

    // Bytes shift in from the bottom, so the first byte of a pixel ends up in
    // the MSBs once the final byte arrives; partial leftovers simply shift out.
    assign assembled = PW'({byte_buf, p_data_in});
    assign byte_en   = (state == CAPTURE) && !vsync_in && href_in;
    assign in_range  = (src_x < X_LIMIT) && (src_y < Y_LIMIT);
    assign keep      = ((src_x & X_MASK) == '0) && ((src_y & Y_MASK) == '0);

    // Frame sync FSM, byte assembly, coordinate tracking and all registered outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state            <= SYNC;
            src_x            <= '0;
            src_y            <= '0;
            phase            <= '0;
            href_d           <= 1'b0;
            byte_buf         <= '0;
            pixel_data_out   <= '0;
            hcount_out       <= '0;
            vcount_out       <= '0;
            pixel_valid_out  <= 1'b0;
            line_done_out    <= 1'b0;
            frame_done_out   <= 1'b0;
            frame_count_out  <= '0;
            overflow_err_out <= 1'b0;
            align_err_out    <= 1'b0;
        end else begin
            pixel_valid_out <= 1'b0;
            line_done_out   <= 1'b0;
            frame_done_out  <= 1'b0;
            href_d          <= byte_en;
            case (state)
                SYNC: begin
                    if (vsync_in) state <= WAIT_START;
                end
                WAIT_START: begin
                    if (!vsync_in) begin
                        state <= CAPTURE;
                        src_x <= '0;
                        src_y <= '0;
                        phase <= '0;
                    end
                end
                CAPTURE: begin
                    if (vsync_in) begin
                        state           <= WAIT_START;
                        frame_done_out  <= 1'b1;
                        frame_count_out <= frame_count_out + 1'b1;
                        phase           <= '0;
                    end else if (href_in) begin
                        byte_buf <= assembled;
                        if (phase == LAST_PHASE) begin
                            phase <= '0;
                            if (in_range) begin
                                src_x <= src_x + 1'b1;
                                if (keep) begin
                                    pixel_valid_out <= 1'b1;
                                    pixel_data_out  <= assembled;
                                    hcount_out      <= HW'(src_x >> DEC_LOG2);
                                    vcount_out      <= VW'(src_y >> DEC_LOG2);
                                end
                            end else begin
                                overflow_err_out <= 1'b1;
                            end
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end else if (href_d) begin
                        line_done_out <= 1'b1;
                        src_x         <= '0;
                        phase         <= '0;
                        if (src_y < Y_LIMIT) src_y <= src_y + 1'b1;
                        if (phase != '0) align_err_out <= 1'b1;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_camera_capture_param.sv
// Scoreboard bench for camera_capture_param: four instances with different
// parameters share one camera bus; a per-instance reference model pushes
// expected pixels when bytes are driven and monitors pop them on pixel_valid_out.
module tb_camera_capture_param;

    logic       clk_in    = 1'b0;
    logic       rst_in    = 1'b1;
    logic       vsync_in  = 1'b0;
    logic       href_in   = 1'b0;
    logic [7:0] p_data_in = 8'h00;

    int cyc = 0;
    int totalChecks = 0;
    int badChecks = 0;

    // Instance parameter sets: A base, B 3-byte pixels, C decimate by 2, D tiny H/V limits.
    int mBpp[4] = '{2, 3, 2, 2};
    int mH[4]   = '{640, 640, 640, 4};
    int mV[4]   = '{480, 480, 480, 4};
    int mDec[4] = '{0, 0, 1, 0};

    int          mX[4], mY[4], mPhase[4], mFrames[4], mLines[4], mFrameDone[4];
    logic [31:0] mAcc[4];
    bit          mInCap[4], mAlign[4], mOvf[4];
    int          lineSeen[4], frameSeen[4];

    typedef struct {
        logic [23:0] data;
        int          h;
        int          v;
        int          c;
    } exp_t;

    exp_t q0[$], q1[$], q2[$], q3[$];

    logic [23:0] pd[4];
    logic [15:0] hc[4], vc[4];
    logic [7:0]  fc[4];
    logic        pv[4], ld[4], fd[4], ae[4], oe[4];

    logic [15:0] pdA, pdC, pdD;
    logic [23:0] pdB;
    logic [9:0]  hcA, hcB, hcC;
    logic [8:0]  vcA, vcB, vcC;
    logic [1:0]  hcD, vcD;

    assign pd[0] = {8'h00, pdA};
    assign pd[1] = pdB;
    assign pd[2] = {8'h00, pdC};
    assign pd[3] = {8'h00, pdD};
    assign hc[0] = {6'd0, hcA};
    assign hc[1] = {6'd0, hcB};
    assign hc[2] = {6'd0, hcC};
    assign hc[3] = {14'd0, hcD};
    assign vc[0] = {7'd0, vcA};
    assign vc[1] = {7'd0, vcB};
    assign vc[2] = {7'd0, vcC};
    assign vc[3] = {14'd0, vcD};

    camera_capture_param #(.BYTES_PER_PIXEL(2), .H_MAX(640), .V_MAX(480), .DEC_LOG2(0), .FRAME_CNT_W(8)) dutA (
        .clk_in(clk_in), .rst_in(rst_in), .vsync_in(vsync_in), .href_in(href_in), .p_data_in(p_data_in),
        .pixel_data_out(pdA), .hcount_out(hcA), .vcount_out(vcA), .pixel_valid_out(pv[0]),
        .line_done_out(ld[0]), .frame_done_out(fd[0]), .frame_count_out(fc[0]),
        .overflow_err_out(oe[0]), .align_err_out(ae[0]));

    camera_capture_param #(.BYTES_PER_PIXEL(3), .H_MAX(640), .V_MAX(480), .DEC_LOG2(0), .FRAME_CNT_W(8)) dutB (
        .clk_in(clk_in), .rst_in(rst_in), .vsync_in(vsync_in), .href_in(href_in), .p_data_in(p_data_in),
        .pixel_data_out(pdB), .hcount_out(hcB), .vcount_out(vcB), .pixel_valid_out(pv[1]),
        .line_done_out(ld[1]), .frame_done_out(fd[1]), .frame_count_out(fc[1]),
        .overflow_err_out(oe[1]), .align_err_out(ae[1]));

    camera_capture_param #(.BYTES_PER_PIXEL(2), .H_MAX(640), .V_MAX(480), .DEC_LOG2(1), .FRAME_CNT_W(8)) dutC (
        .clk_in(clk_in), .rst_in(rst_in), .vsync_in(vsync_in), .href_in(href_in), .p_data_in(p_data_in),
        .pixel_data_out(pdC), .hcount_out(hcC), .vcount_out(vcC), .pixel_valid_out(pv[2]),
        .line_done_out(ld[2]), .frame_done_out(fd[2]), .frame_count_out(fc[2]),
        .overflow_err_out(oe[2]), .align_err_out(ae[2]));

    camera_capture_param #(.BYTES_PER_PIXEL(2), .H_MAX(4), .V_MAX(4), .DEC_LOG2(0), .FRAME_CNT_W(8)) dutD (
        .clk_in(clk_in), .rst_in(rst_in), .vsync_in(vsync_in), .href_in(href_in), .p_data_in(p_data_in),
        .pixel_data_out(pdD), .hcount_out(hcD), .vcount_out(vcD), .pixel_valid_out(pv[3]),
        .line_done_out(ld[3]), .frame_done_out(fd[3]), .frame_count_out(fc[3]),
        .overflow_err_out(oe[3]), .align_err_out(ae[3]));

    // Pixel clock.
    always #5 clk_in = ~clk_in;

    // Cycle index used to pin the expected strobe cycle of every pixel.
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        totalChecks++;
        if (got !== want) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic pushExp(input int i, input exp_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    function automatic int qSize(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic popExp(input int i, output exp_t e);
        case (i)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            2: e = q2.pop_front();
            default: e = q3.pop_front();
        endcase
    endtask

    // Monitor: count strobes and score every emitted pixel against the model.
    always @(negedge clk_in) begin
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            if (ld[i]) lineSeen[i]++;
            if (fd[i]) frameSeen[i]++;
            if (pv[i]) begin
                if (qSize(i) == 0) begin
                    checkOutput($sformatf("i%0d unexpected pixel", i), 32'd1, 32'd0);
                end else begin
                    popExp(i, e);
                    checkOutput($sformatf("i%0d data", i), {8'h00, pd[i]}, {8'h00, e.data});
                    checkOutput($sformatf("i%0d hcount", i), {16'h0, hc[i]}, e.h);
                    checkOutput($sformatf("i%0d vcount", i), {16'h0, vc[i]}, e.v);
                    checkOutput($sformatf("i%0d strobe cycle", i), cyc, e.c);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic modelByte(input logic [7:0] b);
        for (int i = 0; i < 4; i++) begin
            if (mInCap[i]) begin
                mAcc[i] = ((mAcc[i] << 8) | {24'h0, b}) & ((32'd1 << (8 * mBpp[i])) - 32'd1);
                mPhase[i]++;
                if (mPhase[i] == mBpp[i]) begin
                    mPhase[i] = 0;
                    if (mX[i] < mH[i] && mY[i] < mV[i]) begin
                        if ((mX[i] % (1 << mDec[i])) == 0 && (mY[i] % (1 << mDec[i])) == 0)
                            pushExp(i, '{mAcc[i][23:0], mX[i] >> mDec[i], mY[i] >> mDec[i], cyc + 1});
                        mX[i]++;
                    end else begin
                        mOvf[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic modelLineEnd();
        for (int i = 0; i < 4; i++) begin
            if (mInCap[i]) begin
                mLines[i]++;
                if (mPhase[i] != 0) mAlign[i] = 1'b1;
                mPhase[i] = 0;
                mX[i] = 0;
                if (mY[i] < mV[i]) mY[i]++;
            end
        end
    endtask

    task automatic modelFrameEnd();
        for (int i = 0; i < 4; i++) begin
            if (mInCap[i]) begin
                mFrames[i] = (mFrames[i] + 1) % 256;
                mFrameDone[i]++;
                mPhase[i] = 0;
                mInCap[i] = 1'b0;
            end
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            mInCap[i]  = 1'b0;
            mFrames[i] = 0;
            mAlign[i]  = 1'b0;
            mOvf[i]    = 1'b0;
            mPhase[i]  = 0;
            mX[i]      = 0;
            mY[i]      = 0;
        end
    endtask

    task automatic startFrame();
        vsync_in = 1'b1;
        href_in  = 1'b0;
        tick();
        tick();
        vsync_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mInCap[i] = 1'b1;
            mX[i] = 0;
            mY[i] = 0;
            mPhase[i] = 0;
        end
        tick();
        tick();
    endtask

    task automatic endFrame();
        vsync_in = 1'b1;
        href_in  = 1'b0;
        modelFrameEnd();
        tick();
        tick();
    endtask

    // One active line of n bytes: first, first+stride, first+2*stride, ...
    task automatic applyStimulus(input logic [7:0] first, input int n, input logic [7:0] stride);
        for (int k = 0; k < n; k++) begin
            href_in   = 1'b1;
            p_data_in = first + 8'(k) * stride;
            modelByte(p_data_in);
            tick();
        end
        href_in   = 1'b0;
        p_data_in = 8'h00;
        modelLineEnd();
        tick();
        tick();
        tick();
    endtask

    task automatic checkAll(input string tag);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s i%0d line_done count", tag, i), lineSeen[i], mLines[i]);
            checkOutput($sformatf("%s i%0d frame_done count", tag, i), frameSeen[i], mFrameDone[i]);
            checkOutput($sformatf("%s i%0d frame_count", tag, i), {24'h0, fc[i]}, mFrames[i]);
            checkOutput($sformatf("%s i%0d align_err", tag, i), {31'h0, ae[i]}, {31'h0, mAlign[i]});
            checkOutput($sformatf("%s i%0d overflow_err", tag, i), {31'h0, oe[i]}, {31'h0, mOvf[i]});
            checkOutput($sformatf("%s i%0d pending pixels", tag, i), qSize(i), 0);
        end
    endtask

    initial begin
        modelReset();
        for (int i = 0; i < 4; i++) begin
            mLines[i] = 0;
            mFrameDone[i] = 0;
            lineSeen[i] = 0;
            frameSeen[i] = 0;
            mAcc[i] = 32'h0;
        end

        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("reset i%0d valid", i), {31'h0, pv[i]}, 32'd0);
            checkOutput($sformatf("reset i%0d data", i), {8'h0, pd[i]}, 32'd0);
            checkOutput($sformatf("reset i%0d hcount", i), {16'h0, hc[i]}, 32'd0);
            checkOutput($sformatf("reset i%0d frame_count", i), {24'h0, fc[i]}, 32'd0);
            checkOutput($sformatf("reset i%0d errs", i), {30'h0, ae[i], oe[i]}, 32'd0);
        end
        rst_in = 1'b0;
        tick();

        $display("[TB] basic two-byte line");
        startFrame();
        applyStimulus(8'h12, 8, 8'h22);
        endFrame();
        checkAll("basic");

        $display("[TB] three lines of six bytes");
        startFrame();
        for (int l = 0; l < 3; l++) applyStimulus(8'hAA, 6, 8'h11);
        endFrame();
        checkAll("bpp3");

        $display("[TB] four lines of four pixels");
        startFrame();
        for (int l = 0; l < 4; l++) applyStimulus(8'(8'h10 * (l + 1)), 8, 8'h01);
        endFrame();
        checkAll("decimate");

        $display("[TB] misaligned line then clean frame");
        startFrame();
        applyStimulus(8'hC0, 5, 8'h01);
        applyStimulus(8'hD0, 4, 8'h01);
        endFrame();
        checkAll("align");
        startFrame();
        applyStimulus(8'h20, 4, 8'h01);
        endFrame();
        checkAll("align sticky");

        $display("[TB] long line and extra lines");
        startFrame();
        applyStimulus(8'h40, 12, 8'h03);
        for (int l = 0; l < 4; l++) applyStimulus(8'(8'h60 + l), 4, 8'h05);
        endFrame();
        checkAll("overflow");

        $display("[TB] vsync rising mid-line");
        startFrame();
        for (int k = 0; k < 3; k++) begin
            href_in   = 1'b1;
            p_data_in = 8'(8'hE0 + k);
            modelByte(p_data_in);
            tick();
        end
        vsync_in = 1'b1;
        modelFrameEnd();
        for (int k = 0; k < 3; k++) begin
            p_data_in = 8'(8'hF0 + k);
            tick();
        end
        href_in = 1'b0;
        tick();
        tick();
        checkAll("vsync midline");
        startFrame();
        applyStimulus(8'h70, 4, 8'h01);
        endFrame();
        checkAll("after midline");

        $display("[TB] reset mid-line");
        startFrame();
        href_in   = 1'b1;
        p_data_in = 8'h55;
        modelByte(p_data_in);
        tick();
        rst_in = 1'b1;
        modelReset();
        tick();
        tick();
        rst_in = 1'b0;
        for (int k = 0; k < 6; k++) begin
            p_data_in = 8'(8'h90 + k);
            tick();
        end
        href_in = 1'b0;
        tick();
        tick();
        tick();
        checkAll("reset midline");
        startFrame();
        applyStimulus(8'h80, 4, 8'h01);
        endFrame();
        checkAll("after reset");

        $display("[TB] frame counter wrap");
        while (mFrames[0] != 255) begin
            startFrame();
            endFrame();
        end
        checkOutput("frame_count at 255", {24'h0, fc[0]}, 32'd255);
        startFrame();
        endFrame();
        checkAll("wrap");

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
